// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage big-endian data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dmem_state_e;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // raw is {M[A], M[A+1], M[A+2], M[A+3]}; only the leading bytes are meaningful
    function automatic logic [31:0] dmem_fmt_load(input logic [1:0] size, input logic sgn,
                                                  input logic [31:0] raw);
        case (size)
            SZ_BYTE: return {{24{sgn & raw[31]}}, raw[31:24]};
            SZ_HALF: return {{16{sgn & raw[31]}}, raw[31:16]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with four independent lanes; registered read, per-lane write enable.
module dmem_byte_array #(
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   re_i,
    input  logic [3:0]             we_i,
    input  logic [3:0][ADDR_W-1:0] addr_i,
    input  logic [3:0][7:0]        wdata_i,
    output logic [3:0][7:0]        rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]      mem_q [DEPTH];
    logic [3:0][7:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) mem_q[addr_i[k]] <= wdata_i[k];
            if (re_i)    rdata_q[k]       <= mem_q[addr_i[k]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ws_ctrl.sv
// MEM-stage data memory controller: request/response handshake, programmable wait
// states, big-endian byte/half/word access with alignment faults.
module dmem_ws_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1,
    parameter bit ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              ld_ok_q, ld_ok_d;
    logic [1:0]        fsize_q, fsize_d;
    logic              fsgn_q, fsgn_d;

    logic                   fault;
    logic                   commit;
    logic [3:0]             lane_mask;
    logic [31:0]            wshift;
    logic [31:0]            raw;
    logic [3:0]             lane_we;
    logic [3:0][ADDR_W-1:0] lane_addr;
    logic [3:0][7:0]        lane_wd;
    logic [3:0][7:0]        lane_rd;

    assign fault = (req_size == SZ_ILL) ||
                   (ALIGN_CHECK && dmem_misaligned(req_size, req_addr[1:0]));

    // Gated by rst_n so a reset landing on the commit edge drops the access.
    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            ld_ok_q <= 1'b0;
            fsize_q <= SZ_BYTE;
            fsgn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            ld_ok_q <= ld_ok_d;
            fsize_q <= fsize_d;
            fsgn_q  <= fsgn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        err_d     = err_q;
        ld_ok_d   = ld_ok_q;
        fsize_d   = fsize_q;
        fsgn_d    = fsgn_q;
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d  = '{rw: req_rw, size: req_size, sgn: req_signed, wdata: req_wdata};
                    addr_d = req_addr;
                    if (fault) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        ld_ok_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    ld_ok_d = ~req_q.rw;
                    fsize_d = req_q.size;
                    fsgn_d  = req_q.sgn;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Left-justify store data so lane 0 (lowest address) always takes the MSB byte.
    always_comb begin
        lane_mask = 4'b1111;
        wshift    = req_q.wdata;
        case (req_q.size)
            SZ_BYTE: begin
                lane_mask = 4'b0001;
                wshift    = {req_q.wdata[7:0], 24'h0};
            end
            SZ_HALF: begin
                lane_mask = 4'b0011;
                wshift    = {req_q.wdata[15:0], 16'h0};
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane_addr[k]         = addr_q + ADDR_W'(k);
        assign lane_wd[k]           = wshift[31-8*k -: 8];
        assign lane_we[k]           = commit & req_q.rw & lane_mask[k];
        assign raw[31-8*k -: 8]     = lane_rd[k];
    end

    dmem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .re_i    (commit & ~req_q.rw),
        .we_i    (lane_we),
        .addr_i  (lane_addr),
        .wdata_i (lane_wd),
        .rdata_o (lane_rd)
    );

    assign rsp_rdata = ld_ok_q ? dmem_fmt_load(fsize_q, fsgn_q, raw) : 32'h0;
    assign rsp_err   = err_q;
    assign busy      = ~req_ready;

endmodule

// File: tb/tb_dmem_ws_ctrl.sv
// Bench for dmem_ws_ctrl: two instances (1 wait state + alignment check, 3 wait states
// + wrap-around), directed vectors, reset/back-to-back sequences and a random run.
module tb_dmem_ws_ctrl;

    logic             clk = 1'b0;
    logic [1:0]       rst_n = 2'b00;
    logic [1:0]       req_valid = '0, req_ready, req_rw = '0, req_signed = '0;
    logic [1:0][1:0]  req_size = '0;
    logic [1:0][8:0]  req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       rsp_valid, rsp_err, busy;
    logic [1:0][31:0] rsp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mdl [2][512];

    always #5 clk = ~clk;

    dmem_ws_ctrl #(.ADDR_W(9), .WAIT_STATES(1), .ALIGN_CHECK(1)) u_a (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_rw(req_rw[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

    dmem_ws_ctrl #(.ADDR_W(9), .WAIT_STATES(3), .ALIGN_CHECK(0)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_rw(req_rw[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

    typedef struct {
        int          d;
        bit          rw;
        logic [1:0]  sz;
        bit          sg;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t dv[$];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_fault(input int d, input logic [1:0] sz, input logic [8:0] a);
        if (sz == 2'b11) return 1'b1;
        if (d == 1) return 1'b0;
        return (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] m_load(input int d, input logic [1:0] sz, input bit sg,
                                           input logic [8:0] a);
        longint v = 0;
        int nb = nbytes(sz);
        for (int k = 0; k < nb; k++) v = v * 256 + longint'(mdl[d][(int'(a) + k) % 512]);
        if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic m_store(input int d, input logic [1:0] sz, input logic [8:0] a,
                           input logic [31:0] wd);
        int nb = nbytes(sz);
        for (int k = 0; k < nb; k++)
            mdl[d][(int'(a) + k) % 512] = 8'((wd >> (8 * (nb - 1 - k))) & 32'hFF);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input bit rw, input logic [1:0] sz, input bit sg,
                                input logic [8:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input bit ee, input int el);
        vec_t v;
        v.d = d; v.rw = rw; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
        v.exp_rd = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // One complete transaction; returns latency (cycles after accept) or -1 on timeout.
    task automatic xact(input int d, input bit rw, input logic [1:0] sz, input bit sg,
                        input logic [8:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
        int hs_bad = 0;
        lat = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_rw[d] = rw; req_size[d] = sz; req_signed[d] = sg;
        req_addr[d] = a; req_wdata[d] = wd;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0; req_size[d] = 2'($urandom); req_addr[d] = 9'($urandom);
        req_wdata[d] = $urandom; req_rw[d] = 1'($urandom); req_signed[d] = 1'($urandom);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy[d] !== ~req_ready[d] || req_ready[d] !== 1'b0) hs_bad++;
            if (rsp_valid[d]) begin
                lat = n; rd = rsp_rdata[d]; er = rsp_err[d];
                break;
            end
        end
        chk("busy_handshake", 32'(hs_bad), 32'd0);
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
        chk("ready_return", 32'(req_ready[d]), 32'd1);
        chk("rdata_hold", rsp_rdata[d], rd);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd, exp;
        logic        er;

        repeat (3) @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'h0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end

        // directed vectors
        dv.push_back(mk(0, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0, 0, 3));
        dv.push_back(mk(0, 0, 2'b10, 0, 9'h010, 32'h0, 32'hDEADBEEF, 0, 3));
        dv.push_back(mk(0, 0, 2'b00, 1, 9'h011, 32'h0, 32'hFFFFFFAD, 0, 3));
        dv.push_back(mk(0, 0, 2'b00, 0, 9'h011, 32'h0, 32'h000000AD, 0, 3));
        dv.push_back(mk(0, 0, 2'b01, 1, 9'h012, 32'h0, 32'hFFFFBEEF, 0, 3));
        dv.push_back(mk(0, 0, 2'b01, 0, 9'h012, 32'h0, 32'h0000BEEF, 0, 3));
        dv.push_back(mk(0, 1, 2'b10, 0, 9'h020, 32'hA1B2C3D4, 32'h0, 0, 3));
        dv.push_back(mk(0, 1, 2'b01, 0, 9'h021, 32'h00005555, 32'h0, 1, 1));
        dv.push_back(mk(0, 0, 2'b10, 0, 9'h020, 32'h0, 32'hA1B2C3D4, 0, 3));
        dv.push_back(mk(0, 0, 2'b11, 0, 9'h000, 32'h0, 32'h0, 1, 1));
        dv.push_back(mk(0, 0, 2'b10, 0, 9'h012, 32'h0, 32'h0, 1, 1));
        dv.push_back(mk(0, 1, 2'b10, 0, 9'h1FC, 32'h01020304, 32'h0, 0, 3));
        dv.push_back(mk(0, 0, 2'b01, 0, 9'h1FE, 32'h0, 32'h00000304, 0, 3));
        dv.push_back(mk(1, 1, 2'b10, 0, 9'h1FE, 32'h11223344, 32'h0, 0, 5));
        dv.push_back(mk(1, 0, 2'b00, 0, 9'h1FE, 32'h0, 32'h00000011, 0, 5));
        dv.push_back(mk(1, 0, 2'b00, 0, 9'h1FF, 32'h0, 32'h00000022, 0, 5));
        dv.push_back(mk(1, 0, 2'b00, 0, 9'h000, 32'h0, 32'h00000033, 0, 5));
        dv.push_back(mk(1, 0, 2'b00, 0, 9'h001, 32'h0, 32'h00000044, 0, 5));
        dv.push_back(mk(1, 0, 2'b10, 0, 9'h1FE, 32'h0, 32'h11223344, 0, 5));
        dv.push_back(mk(1, 0, 2'b01, 1, 9'h1FF, 32'h0, 32'h00002233, 0, 5));
        dv.push_back(mk(1, 1, 2'b01, 0, 9'h1FF, 32'hFFFF99AA, 32'h0, 0, 5));
        dv.push_back(mk(1, 0, 2'b10, 1, 9'h1FE, 32'h0, 32'h1199AA44, 0, 5));
        dv.push_back(mk(1, 0, 2'b11, 1, 9'h003, 32'h0, 32'h0, 1, 1));

        foreach (dv[i]) begin
            xact(dv[i].d, dv[i].rw, dv[i].sz, dv[i].sg, dv[i].a, dv[i].wd, lat, rd, er);
            chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(dv[i].exp_lat));
            chk($sformatf("dir%0d_rdata", i), rd, dv[i].exp_rd);
            chk($sformatf("dir%0d_err", i), 32'(er), 32'(dv[i].exp_err));
        end

        // fill both memories so the model knows every byte
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 512; a += 4) begin
                exp = $urandom;
                xact(d, 1'b1, 2'b10, 1'b0, 9'(a), exp, lat, rd, er);
                chk("fill_err", 32'(er), 32'd0);
                m_store(d, 2'b10, 9'(a), exp);
            end
        end

        // reset lands on the commit edge of a pending store (3 wait states)
        @(negedge clk);
        exp = ~m_load(1, 2'b10, 1'b0, 9'h040);
        req_valid[1] = 1'b1; req_rw[1] = 1'b1; req_size[1] = 2'b10; req_addr[1] = 9'h040;
        req_wdata[1] = exp;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(negedge clk);
        chk("rstmid_no_rsp_r", 32'(rsp_valid[1]), 32'd0);
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 32'(req_ready[1]), 32'd1);
        chk("rstmid_rdata", rsp_rdata[1], 32'h0);
        chk("rstmid_valid", 32'(rsp_valid[1]), 32'd0);
        xact(1, 1'b0, 2'b10, 1'b0, 9'h040, 32'h0, lat, rd, er);
        chk("rstmid_mem_kept", rd, m_load(1, 2'b10, 1'b0, 9'h040));

        // back-to-back: requester holds req_valid while the block is busy
        begin
            int nacc = 0, nrsp = 0, last = -100, gap_bad = 0, bb = 0, rd_bad = 0;
            exp = m_load(0, 2'b10, 1'b0, 9'h010);
            @(negedge clk);
            req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_size[0] = 2'b10; req_signed[0] = 1'b0;
            req_addr[0] = 9'h010;
            for (int c = 0; c < 24; c++) begin
                if (busy[0] !== ~req_ready[0]) bb++;
                if (req_ready[0]) begin
                    if (nacc > 0 && c - last != ws_of(0) + 3) gap_bad++;
                    last = c;
                    nacc++;
                end
                if (rsp_valid[0]) begin
                    nrsp++;
                    if (rsp_rdata[0] !== exp || rsp_err[0] !== 1'b0) rd_bad++;
                end
                @(negedge clk);
            end
            req_valid[0] = 1'b0;
            chk("b2b_accepts", 32'(nacc), 32'd6);
            chk("b2b_gap", 32'(gap_bad), 32'd0);
            chk("b2b_busy", 32'(bb), 32'd0);
            chk("b2b_rsps", 32'(nrsp), 32'd6);
            chk("b2b_rdata", 32'(rd_bad), 32'd0);
        end

        // random traffic against the byte-level model
        for (int i = 0; i < 300; i++) begin
            int          d  = int'($urandom_range(0, 1));
            bit          rw = 1'($urandom);
            logic [1:0]  sz = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
            bit          sg = 1'($urandom);
            logic [8:0]  a  = 9'($urandom);
            logic [31:0] wd = $urandom;
            bit          f;
            if ($urandom_range(0, 9) < 7) a = (sz == 2'b10) ? (a & 9'h1FC) :
                                              (sz == 2'b01) ? (a & 9'h1FE) : a;
            f = m_fault(d, sz, a);
            xact(d, rw, sz, sg, a, wd, lat, rd, er);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), f ? 32'd1 : 32'(ws_of(d) + 2));
            chk($sformatf("rnd%0d_err", i), 32'(er), 32'(f));
            chk($sformatf("rnd%0d_rdata", i), rd, (f || rw) ? 32'h0 : m_load(d, sz, sg, a));
            if (!f && rw) m_store(d, sz, a, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_bad);
        $fatal(1);
    end

endmodule
